// File: rtl/calc_alu_seq.sv
// Registered calculator ALU: single-cycle logic/arith ops, iterative shift-add multiply.
// Define CALC_ALU_DIV_EN to build the restoring divider for opcode 110.
module calc_alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   a_q, a_d, acc_q, acc_d, acc_mul;
    logic [WIDTH-1:0]     b_q, b_d, result_q, result_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
    logic                 load;
    logic [WIDTH:0]       sum, diff;
    logic                 add_ovf, sub_ovf;

    assign sum     = {1'b0, A} + {1'b0, B};
    assign diff    = {1'b0, A} - {1'b0, B};
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    assign acc_mul = b_q[0] ? acc_q + a_q : acc_q;

`ifdef CALC_ALU_DIV_EN
    // Divide reuses acc_q as {remainder, quotient}; a_q shifts the dividend out MSB-first.
    logic           div_q, div_d;
    logic [WIDTH:0] rem_sh, rem_sub;
    logic           rem_ge;
    logic [WIDTH-1:0] rem_n, quo_n;

    assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, b_q};
    assign rem_ge  = rem_sh >= {1'b0, b_q};
    assign rem_n   = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_n   = {acc_q[WIDTH-2:0], rem_ge};
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        load     = 1'b0;
`ifdef CALC_ALU_DIV_EN
        div_d    = div_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    load     = 1'b1;
                    state_d  = StDone;
                    result_d = '0;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    case (opcode)
                        3'b000: begin
                            result_d = sum[WIDTH-1:0];
                            carry_d  = sum[WIDTH];
                            ovf_d    = add_ovf;
                        end
                        3'b001: begin
                            result_d = diff[WIDTH-1:0];
                            carry_d  = diff[WIDTH];
                            ovf_d    = sub_ovf;
                        end
                        3'b010: result_d = A & B;
                        3'b011: result_d = A | B;
                        3'b100: result_d = ~A;
                        3'b101: begin
                            load    = 1'b0;
                            state_d = StBusy;
                            a_d     = {{WIDTH{1'b0}}, A};
                            b_d     = B;
                            acc_d   = '0;
                            cnt_d   = '0;
`ifdef CALC_ALU_DIV_EN
                            div_d   = 1'b0;
`endif
                        end
`ifdef CALC_ALU_DIV_EN
                        3'b110: begin
                            if (B == '0) begin
                                result_d = '1;
                                err_d    = 1'b1;
                            end else begin
                                load    = 1'b0;
                                state_d = StBusy;
                                a_d     = {{WIDTH{1'b0}}, A};
                                b_d     = B;
                                acc_d   = '0;
                                cnt_d   = '0;
                                div_d   = 1'b1;
                            end
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CNT_W'(1);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                acc_d = acc_mul;
`ifdef CALC_ALU_DIV_EN
                if (div_q) begin
                    b_d   = b_q;
                    acc_d = {rem_n, quo_n};
                end
`endif
                // Last iteration registers the result directly, giving WIDTH+1 total latency.
                if (cnt_q == CntLast) begin
                    load     = 1'b1;
                    state_d  = StDone;
                    result_d = acc_mul[WIDTH-1:0];
                    carry_d  = 1'b0;
                    ovf_d    = |acc_mul[2*WIDTH-1:WIDTH];
                    err_d    = 1'b0;
`ifdef CALC_ALU_DIV_EN
                    if (div_q) begin
                        result_d = quo_n;
                        ovf_d    = 1'b0;
                    end
`endif
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (load) zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef CALC_ALU_DIV_EN
            div_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
`ifdef CALC_ALU_DIV_EN
            div_q    <= div_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Bench for calc_alu_seq (WIDTH=8): directed cases plus random ops against an arithmetic model.
module tb_calc_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic [2:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry, zero, ovf, err;

    int n_checks = 0;
    int n_errors = 0;

    calc_alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference behaviour from the operation definitions, using integer arithmetic.
    task automatic model(input int op, input int a, input int b,
                         output int res, output int c, output int z,
                         output int o, output int e, output int lat);
        int s;
        res = 0; c = 0; o = 0; e = 0; lat = 1;
        case (op)
            0: begin
                res = (a + b) % 256;
                c   = (a + b > 255) ? 1 : 0;
                s   = to_signed8(a) + to_signed8(b);
                o   = (s > 127 || s < -128) ? 1 : 0;
            end
            1: begin
                res = (a - b + 256) % 256;
                c   = (a < b) ? 1 : 0;
                s   = to_signed8(a) - to_signed8(b);
                o   = (s > 127 || s < -128) ? 1 : 0;
            end
            2: res = a & b;
            3: res = a | b;
            4: res = 255 - a;
            5: begin
                res = (a * b) % 256;
                o   = (a * b > 255) ? 1 : 0;
                lat = 9;
            end
`ifdef CALC_ALU_DIV_EN
            6: begin
                if (b == 0) begin
                    res = 255;
                    e   = 1;
                end else begin
                    res = a / b;
                    lat = 9;
                end
            end
`endif
            default: e = 1;
        endcase
        z = (res == 0) ? 1 : 0;
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic run_op(input int op, input int a, input int b, input int hold);
        int r, c, z, o, e, l, lat;
        logic [7:0] held;
        model(op, a, b, r, c, z, o, e, l);
        check("idle_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        A        = 8'(a);
        B        = 8'(b);
        opcode   = 3'(op);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = 8'($urandom);
        B        = 8'($urandom);
        opcode   = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, l);
        if (!out_valid) return;
        check("result", 32'(result), r);
        check("carry", 32'(carry), c);
        check("zero", 32'(zero), z);
        check("ovf", 32'(ovf), o);
        check("err", 32'(err), e);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 1);
            check("hold_result", 32'(result), 32'(held));
            check("hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drop_valid", 32'(out_valid), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        opcode    = '0;
        #2;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_result", 32'(result), 0);
        check("rst_err", 32'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", 32'(in_ready), 1);

        // Abort a multiply with reset mid-BUSY.
        in_valid = 1'b1; A = 8'd12; B = 8'd13; opcode = 3'b101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_ready", 32'(in_ready), 0);
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(out_valid), 0);
        check("abort_result", 32'(result), 0);
        check("abort_flags", 32'({carry, zero, ovf, err}), 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", 32'(in_ready), 1);
        check("abort_novalid", 32'(out_valid), 0);

        run_op(0, 200, 100, 0);
        run_op(1, 3, 5, 1);
        run_op(0, 100, 100, 0);
        run_op(1, 128, 1, 0);
        run_op(5, 15, 17, 0);
        run_op(5, 16, 16, 2);
        run_op(4, 8'h0F, 0, 5);
        run_op(7, 9, 9, 0);
        run_op(6, 200, 7, 0);
        run_op(6, 5, 0, 0);
        run_op(0, 255, 1, 0);
        run_op(5, 255, 255, 0);

        for (int i = 0; i < 60; i++) begin
            int a, b;
            a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            run_op(int'($urandom_range(0, 7)), a, b, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
